// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner sequencer for the shared tri-state data bus.
// It drives the buffer enables so that at most one buffer drives the bus at a time.
// Between two owners it inserts an idle turnaround of TURN_CYCLES cycles.
// Optional macro BUS_ARB_TIMEOUT_EN enables forced revocation after MAX_HOLD cycles.
// When the macro is absent there is no hold counter and timeout is tied low.
module bus_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         bus_en,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     bus_busy,
  output logic                     timeout
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [2:0]        turn_cnt_q, turn_cnt_d;
  logic [N_REQ-1:0]  bus_en_d;
  logic [ID_W-1:0]   grant_id_d;
  logic              bus_busy_d;
  logic [ID_W:0]     pick;
  logic              drop;
`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0]        hold_q, hold_d;
  logic              timeout_d;
`endif

  if (N_REQ < 2 || N_REQ > 16 || TURN_CYCLES < 1 || TURN_CYCLES > 7 ||
      MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
    $error("bus_arbiter: parameter out of range");
  end

  // First set request at or above ptr, wrapping modulo N_REQ; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] cand;
    int              idx;
    res = '0;
    // Walk from the far end so the nearest candidate is written last and wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx  = (int'(ptr) + k) % N_REQ;
      cand = ID_W'(idx);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // Requester following id in round-robin order.
  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] id);
    return (int'(id) == N_REQ - 1) ? '0 : id + ID_W'(1);
  endfunction

  // Next-state and next-output decode; every output comes straight from a register.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    turn_cnt_d = turn_cnt_q;
    bus_en_d   = bus_en;
    grant_id_d = grant_id;
    bus_busy_d = bus_busy;
    pick       = rr_pick(req, rr_ptr_q);
    drop       = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d     = hold_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick[ID_W]) begin
          bus_en_d   = N_REQ'(1) << pick[ID_W-1:0];
          grant_id_d = pick[ID_W-1:0];
          bus_busy_d = 1'b1;
          state_d    = GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d     = '0;
`endif
        end
      end
      GRANT: begin
        drop = !req[grant_id];
`ifdef BUS_ARB_TIMEOUT_EN
        if (!drop && hold_q == 8'(MAX_HOLD - 1)) begin
          drop      = 1'b1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
        // A release and a revocation follow the same path into the turnaround.
        if (drop) begin
          bus_en_d   = '0;
          bus_busy_d = 1'b0;
          rr_ptr_d   = ptr_after(grant_id);
          turn_cnt_d = '0;
          state_d    = TURN;
        end
      end
      TURN: begin
        if (turn_cnt_q == 3'(TURN_CYCLES - 1)) begin
          turn_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops the bus immediately with no turnaround.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      turn_cnt_q <= '0;
      bus_en     <= '0;
      grant_id   <= '0;
      bus_busy   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q     <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      turn_cnt_q <= turn_cnt_d;
      bus_en     <= bus_en_d;
      grant_id   <= grant_id_d;
      bus_busy   <= bus_busy_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q     <= hold_d;
      timeout    <= timeout_d;
`endif
    end
  end

`ifndef BUS_ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus random requests against an ownership model.
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int TC = 1;
  localparam int MH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] bus_en;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus, who owned it last, where the next search starts,
  // idle cycles seen since the last release, cycles held by the current owner.
  int m_owner, m_last, m_ptr, m_wait, m_hold;
  bit m_to;

  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(N), .TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bus_en(bus_en),
    .grant_id(grant_id), .bus_busy(bus_busy), .timeout(timeout)
  );

  function automatic logic [3:0] m_en();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  task automatic model_step();
    logic [1:0] cand;
    m_to = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_wait = TC; m_hold = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_wait = 0;
      end else begin
        m_hold++;
        if (TO_ON && m_hold == MH) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_wait = 0; m_to = 1'b1;
        end
      end
    end else if (m_wait < TC) begin
      m_wait++;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = 2'((m_ptr + k) % N);
        if (m_owner < 0 && req[cand]) m_owner = int'(cand);
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_hold = 0;
      end
    end
  endtask

  // One clock: the model samples the same inputs as the DUT, outputs are read on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      cyc();
      checks++;
      if (bus_en !== 4'b0000 || bus_busy !== 1'b0) begin
        errors++; $display("FAIL reset_hold cyc %0d: bus_en=%b busy=%b, expected 0000 0", c, bus_en, bus_busy);
      end
      checks++;
      if (grant_id !== 2'd0 || timeout !== 1'b0) begin
        errors++; $display("FAIL reset_vals cyc %0d: grant_id=%0d timeout=%b, expected 0 0", c, grant_id, timeout);
      end
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (bus_en !== 4'b0001 || bus_busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_first_grant: bus_en=%b busy=%b id=%0d, expected 0001 1 0", bus_en, bus_busy, grant_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks++;
      if (bus_en !== 4'b0100 || bus_busy !== 1'b1 || grant_id !== 2'd2) begin
        errors++; $display("FAIL single_hold cyc %0d: bus_en=%b busy=%b id=%0d, expected 0100 1 2", c, bus_en, bus_busy, grant_id);
      end
    end
    req = 4'b0000;
    cyc();
    checks++;
    if (bus_en !== 4'b0000 || bus_busy !== 1'b0 || grant_id !== 2'd2) begin
      errors++; $display("FAIL single_release: bus_en=%b busy=%b id=%0d, expected 0000 0 2", bus_en, bus_busy, grant_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int ngr = 0, own = 0, zero_run = 0, idx;
    logic [3:0] prev = 4'b0000;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 80 && ngr < 5; c++) begin
      cyc();
      checks++;
      if (bus_en !== m_en() || bus_busy !== (m_owner >= 0)) begin
        errors++; $display("FAIL rr_model cyc %0d: bus_en=%b busy=%b, expected %b %b", c, bus_en, bus_busy, m_en(), m_owner >= 0);
      end
      if (bus_en != 4'b0000) begin
        if (prev == 4'b0000) begin
          idx = -1;
          for (int b = 0; b < N; b++) if (bus_en[b]) idx = b;
          checks++;
          if (idx != exp_order[ngr]) begin
            errors++; $display("FAIL rr_order grant %0d: owner=%0d, expected %0d", ngr, idx, exp_order[ngr]);
          end
          if (ngr > 0) begin
            checks++;
            if (zero_run < TC + 1) begin
              errors++; $display("FAIL rr_gap grant %0d: idle cycles=%0d, expected >= %0d", ngr, zero_run, TC + 1);
            end
          end
          ngr++; own = 0;
        end
        own++; zero_run = 0;
      end else begin
        zero_run++;
      end
      prev = bus_en;
      req = (own == 2 && m_owner >= 0) ? (4'b1111 & ~m_en()) : 4'b1111;
    end
    checks++;
    if (ngr != 5) begin
      errors++; $display("FAIL rr_budget: grants seen=%0d, expected 5", ngr);
    end
    req = 4'b0000;
  endtask

  task automatic test_no_preempt();
    int waited = 0;
    do_reset();
    req = 4'b1000;
    cyc();
    checks++;
    if (bus_en !== 4'b1000 || grant_id !== 2'd3) begin
      errors++; $display("FAIL np_grant3: bus_en=%b id=%0d, expected 1000 3", bus_en, grant_id);
    end
    req = 4'b1011;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if (bus_en !== 4'b1000) begin
        errors++; $display("FAIL np_hold cyc %0d: bus_en=%b, expected 1000", c, bus_en);
      end
    end
    req = 4'b0011;
    cyc();
    checks++;
    if (bus_en !== 4'b0000 || bus_busy !== 1'b0) begin
      errors++; $display("FAIL np_release: bus_en=%b busy=%b, expected 0000 0", bus_en, bus_busy);
    end
    while (bus_en == 4'b0000 && waited < 10) begin
      cyc(); waited++;
    end
    checks++;
    if (bus_en !== 4'b0001 || waited != TC + 1) begin
      errors++; $display("FAIL np_wrap: bus_en=%b after %0d cycles, expected 0001 after %0d", bus_en, waited, TC + 1);
    end
    req = 4'b0000;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010;
    cyc();
    checks++;
    if (bus_en !== 4'b0010) begin
      errors++; $display("FAIL mr_grant1: bus_en=%b, expected 0010", bus_en);
    end
    req = 4'b0011; rst_n = 1'b0;
    cyc();
    checks++;
    if (bus_en !== 4'b0000 || bus_busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL mr_clear: bus_en=%b busy=%b id=%0d, expected 0000 0 0", bus_en, bus_busy, grant_id);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (bus_en !== 4'b0001 || grant_id !== 2'd0) begin
      errors++; $display("FAIL mr_regrant: bus_en=%b id=%0d, expected 0001 0", bus_en, grant_id);
    end
    req = 4'b0000;
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] exp_en[7]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010};
    logic       exp_to[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 7; c++) begin
      cyc();
      checks++;
      if (bus_en !== exp_en[c] || timeout !== exp_to[c]) begin
        errors++; $display("FAIL to_seq cyc %0d: bus_en=%b timeout=%b, expected %b %b", c, bus_en, timeout, exp_en[c], exp_to[c]);
      end
    end
    req = 4'b0000;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = req ^ (4'($urandom) & 4'($urandom));
      rst_n = ($urandom_range(0, 63) != 0);
      cyc();
      checks++;
      if (bus_en !== m_en() || bus_busy !== (m_owner >= 0) || grant_id !== 2'(m_last) || timeout !== m_to) begin
        errors++;
        $display("FAIL rand cyc %0d: bus_en=%b busy=%b id=%0d to=%b, expected %b %b %0d %b",
                 c, bus_en, bus_busy, grant_id, timeout, m_en(), m_owner >= 0, m_last, m_to);
      end
      checks++;
      if ($countones(bus_en) > 1) begin
        errors++; $display("FAIL rand_onehot cyc %0d: bus_en=%b, expected at most one bit", c, bus_en);
      end
    end
    rst_n = 1'b1; req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_mid_reset();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter/sequencer for the shared 16-bit tri-state data bus. Owns the `en` inputs of every `buffer` instance that drives the bus. Guarantees at most one driver at a time, with a programmable idle turnaround between owners so no two buffers ever drive together. Sits beside the bus in the CPU datapath; requesters are the register/ALU/memory-side buffer owners.

Parameters:
- N_REQ, 4: number of requesters/buffers sharing the bus (2..16).
- TURN_CYCLES, 1: bus-idle cycles between one grant ending and the next starting (1..7).
- MAX_HOLD, 16: maximum cycles one owner may hold the bus; used only with the optional feature (1..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N_REQ  per-requester bus request; level, held high while bus wanted.
- bus_en  output  N_REQ  one-hot (or zero) enable to buffer i; wired to buffer `en`.
- grant_id  output  clog2(N_REQ)  index of current owner; valid only when bus_busy=1.
- bus_busy  output  1  high while any bus_en bit is high.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked (optional feature only; tied 0 otherwise).

Behaviour:
- One clock (`clk`). Reset is synchronous and active-low: sampled on the rising edge of `clk` while rst_n=0.
- Reset values: bus_en=0, grant_id=0, bus_busy=0, timeout=0, state=IDLE, rr_ptr=0, turnaround counter=0.
- All outputs are registered.
- Invariant: popcount(bus_en) <= 1 in every cycle, including the cycle after reset and after any req change.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit scanning from rr_ptr upward, modulo N_REQ.
  - At that edge: bus_en[i]=1, grant_id=i, bus_busy=1, and go to GRANT.
  - Latency: req rising, sampled at edge k, produces bus_en high after edge k.
- State GRANT:
  - Owner i keeps the bus while req[i]=1. Other req bits are ignored and do not preempt.
  - When req[i]=0 is sampled: bus_en=0, bus_busy=0, rr_ptr=(i+1) mod N_REQ, and go to TURN.
- State TURN:
  - bus_en stays 0 for exactly TURN_CYCLES cycles, then go to IDLE.
  - Requests that arrive during TURN are held pending, not lost, because req is level.
  - Arbitration happens on the first IDLE edge.
  - Minimum gap from one bus_en falling to the next rising is TURN_CYCLES+1 edges.
- Fairness:
  - With all requesters continuously requesting and releasing, the grant order is strictly i, i+1, ... mod N_REQ.
  - No requester waits for more than N_REQ-1 other grants.
- Simultaneous events:
  - The owner releasing while another requester raises req in the same cycle is handled by the normal GRANT->TURN path.
  - Multiple new requests in IDLE resolve by rr_ptr order only.
- Reset mid-operation: rst_n=0 in any state clears bus_en on that edge, with no turnaround. rr_ptr returns to 0.
- grant_id holds its last value when bus_busy=0. Consumers must qualify it with bus_busy.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter resets to 0 on each grant and increments every GRANT cycle.
  - When it reaches MAX_HOLD with req[i] still high, the arbiter revokes the grant: bus_en=0, timeout=1 for one cycle, rr_ptr=(i+1) mod N_REQ, and go to TURN.
  - The offender may be re-granted only after the other pending requesters have had their turn.
- Undefined:
  - No counter is built and timeout is tied 0.
  - Hold time is unbounded.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=4'b1111 -> bus_en=0, bus_busy=0 throughout. First grant after release goes to index 0 (bus_en=4'b0001) one edge after rst_n=1.
- Single requester: req=4'b0100 for 5 cycles then 0 -> bus_en=4'b0100 from the edge after req rises, for 5 cycles, then 0. bus_busy mirrors it. grant_id=2.
- Round-robin: req=4'b1111, each owner drops req for 1 cycle after 2 cycles of ownership, TURN_CYCLES=1 -> grant order 0,1,2,3,0. bus_en stays 0 for at least 2 edges between grants.
- No preemption: owner 3 holds the bus while req[0] and req[1] rise -> bus_en stays 4'b1000 until req[3] falls. Next grant goes to 0 (rr_ptr wrapped from 3 to 0).
- Mid-grant reset: rst_n=0 while bus_en=4'b0010 -> bus_en=0 on that edge. After release with req=4'b0011, the grant goes to 0, not 2.
- BUS_ARB_TIMEOUT_EN with MAX_HOLD=4: req=4'b0011 held constantly -> owner 0 revoked after 4 cycles with timeout pulsing once. Owner 1 is granted after the turnaround. No cycle ever shows popcount(bus_en)>1.
